// File: rtl/vlane_shift_sequencer_if.sv
// Command, register-file, shifter and writeback signals of the vector-lane shift sequencer.
// The sequencer connects through the master modport; its environment uses slave.
interface vlane_shift_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LOG2WIDTH = 5,
    parameter int unsigned LOG2MVL   = 5,
    parameter int unsigned REGIDW    = 5
);
    logic                 start;
    logic [1:0]           cmd_op;
    logic [LOG2MVL:0]     cmd_vl;
    logic [REGIDW-1:0]    cmd_src;
    logic [REGIDW-1:0]    cmd_dst;
    logic                 cmd_sa_vec;
    logic [LOG2WIDTH-1:0] cmd_sa_scalar;

    logic [REGIDW-1:0]    rf_a_addr;
    logic [REGIDW-1:0]    rf_b_addr;
    logic [WIDTH-1:0]     rf_a_data;
    logic [WIDTH-1:0]     rf_b_data;
    logic                 rf_re;

    logic [WIDTH-1:0]     sh_opB;
    logic [LOG2WIDTH-1:0] sh_sa;
    logic [1:0]           sh_op;
    logic [WIDTH-1:0]     sh_result;

    logic                 wb_valid;
    logic [REGIDW-1:0]    wb_addr;
    logic [WIDTH-1:0]     wb_data;
    logic                 wb_ready;

    logic                 busy;
    logic                 done;

    modport master (
        input  start, cmd_op, cmd_vl, cmd_src, cmd_dst, cmd_sa_vec, cmd_sa_scalar,
        input  rf_a_data, rf_b_data, sh_result, wb_ready,
        output rf_a_addr, rf_b_addr, rf_re, sh_opB, sh_sa, sh_op,
        output wb_valid, wb_addr, wb_data, busy, done
    );

    modport slave (
        output start, cmd_op, cmd_vl, cmd_src, cmd_dst, cmd_sa_vec, cmd_sa_scalar,
        output rf_a_data, rf_b_data, sh_result, wb_ready,
        input  rf_a_addr, rf_b_addr, rf_re, sh_opB, sh_sa, sh_op,
        input  wb_valid, wb_addr, wb_data, busy, done
    );
endinterface

// File: rtl/vlane_shift_sequencer.sv
// Vector shift element sequencer: issues RF reads, feeds the lane shifter and
// collects results with their destination addresses into a 4-entry writeback FIFO.
module vlane_shift_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LOG2WIDTH = 5,
    parameter int unsigned LOG2MVL   = 5,
    parameter int unsigned REGIDW    = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    vlane_shift_sequencer_if.master bus
);
    localparam int unsigned VLW        = LOG2MVL + 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTRW       = 2;
    localparam int unsigned CNTW       = 3;
    localparam int unsigned CRW        = 4;
    localparam int unsigned ENTRYW     = REGIDW + WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [VLW-1:0]       idx_q, idx_d, vl_q, vl_d;
    logic [REGIDW-1:0]    src_q, src_d, dst_q, dst_d;
    logic [1:0]           op_q, op_d;
    logic                 sa_vec_q, sa_vec_d;
    logic [LOG2WIDTH-1:0] sa_scalar_q, sa_scalar_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic                 rf_re_q, rf_re_d;
    logic [REGIDW-1:0]    rf_addr_q, rf_addr_d, iss_dst_q, iss_dst_d;
    logic                 d_valid_q, d_valid_d;
    logic [REGIDW-1:0]    d_dst_q, d_dst_d;
    logic [WIDTH-1:0]     sh_opb_q, sh_opb_d;
    logic [LOG2WIDTH-1:0] sh_sa_q, sh_sa_d;
    logic [1:0]           sh_op_q, sh_op_d;
    logic                 r_valid_q, r_valid_d;
    logic [REGIDW-1:0]    r_dst_q, r_dst_d;

    logic [ENTRYW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 push, pop, credit_ok, pipe_empty;
    logic [ENTRYW-1:0]    head;
    logic                 unused_rf_b;

    assign push       = r_valid_q;
    assign pop        = (count_q != '0) && bus.wb_ready;
    assign pipe_empty = !rf_re_q && !d_valid_q && !r_valid_q;
    // Count every element that will still need a FIFO slot after this edge.
    assign credit_ok  = (CRW'(rf_re_q) + CRW'(d_valid_q) + CRW'(r_valid_q)
                         + CRW'(count_q) - CRW'(pop)) < CRW'(FIFO_DEPTH);

    // Command FSM; the first element issues on the same edge that accepts start.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        src_d       = src_q;
        dst_d       = dst_q;
        op_d        = op_q;
        sa_vec_d    = sa_vec_q;
        sa_scalar_d = sa_scalar_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rf_re_d     = 1'b0;
        rf_addr_d   = '0;
        iss_dst_d   = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vl_d        = bus.cmd_vl;
                    src_d       = bus.cmd_src;
                    dst_d       = bus.cmd_dst;
                    op_d        = (bus.cmd_op == 2'b10) ? 2'b00 : bus.cmd_op;
                    sa_vec_d    = bus.cmd_sa_vec;
                    sa_scalar_d = bus.cmd_sa_scalar;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                    if (bus.cmd_vl == '0) begin
                        state_d = DRAIN;
                    end else begin
                        rf_re_d   = 1'b1;
                        rf_addr_d = bus.cmd_src;
                        iss_dst_d = bus.cmd_dst;
                        idx_d     = VLW'(1);
                        state_d   = (bus.cmd_vl == VLW'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    rf_re_d   = 1'b1;
                    rf_addr_d = src_q + REGIDW'(idx_q);
                    iss_dst_d = dst_q + REGIDW'(idx_q);
                    idx_d     = idx_q + VLW'(1);
                    if (idx_q == vl_q - VLW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty && (count_q - CNTW'(pop)) == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage D drives the shifter; stage R captures its result one cycle later.
    always_comb begin
        d_valid_d = rf_re_q;
        d_dst_d   = iss_dst_q;
        sh_opb_d  = '0;
        sh_sa_d   = '0;
        sh_op_d   = '0;
        if (rf_re_q) begin
            sh_opb_d = bus.rf_a_data;
            sh_sa_d  = sa_vec_q ? bus.rf_b_data[LOG2WIDTH-1:0] : sa_scalar_q;
            sh_op_d  = op_q;
        end
        r_valid_d = d_valid_q;
        r_dst_d   = d_dst_q;
        wr_ptr_d  = wr_ptr_q + PTRW'(push);
        rd_ptr_d  = rd_ptr_q + PTRW'(pop);
        count_d   = count_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vl_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            op_q        <= '0;
            sa_vec_q    <= 1'b0;
            sa_scalar_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_re_q     <= 1'b0;
            rf_addr_q   <= '0;
            iss_dst_q   <= '0;
            d_valid_q   <= 1'b0;
            d_dst_q     <= '0;
            sh_opb_q    <= '0;
            sh_sa_q     <= '0;
            sh_op_q     <= '0;
            r_valid_q   <= 1'b0;
            r_dst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vl_q        <= vl_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            op_q        <= op_d;
            sa_vec_q    <= sa_vec_d;
            sa_scalar_q <= sa_scalar_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_re_q     <= rf_re_d;
            rf_addr_q   <= rf_addr_d;
            iss_dst_q   <= iss_dst_d;
            d_valid_q   <= d_valid_d;
            d_dst_q     <= d_dst_d;
            sh_opb_q    <= sh_opb_d;
            sh_sa_q     <= sh_sa_d;
            sh_op_q     <= sh_op_d;
            r_valid_q   <= r_valid_d;
            r_dst_q     <= r_dst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {r_dst_q, bus.sh_result};
    end

    assign head          = fifo_mem[rd_ptr_q];
    assign bus.wb_valid  = (count_q != '0);
    assign bus.wb_addr   = bus.wb_valid ? head[WIDTH +: REGIDW] : '0;
    assign bus.wb_data   = bus.wb_valid ? head[WIDTH-1:0] : '0;
    assign bus.rf_re     = rf_re_q;
    assign bus.rf_a_addr = rf_addr_q;
    assign bus.rf_b_addr = rf_addr_q;
    assign bus.sh_opB    = sh_opb_q;
    assign bus.sh_sa     = sh_sa_q;
    assign bus.sh_op     = sh_op_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign unused_rf_b   = ^bus.rf_b_data[WIDTH-1:LOG2WIDTH];
endmodule

// File: tb/tb_vlane_shift_sequencer.sv
// Scoreboard bench for vlane_shift_sequencer: directed commands push expected
// writebacks; a forked monitor pops and compares on every accepted writeback.
module tb_vlane_shift_sequencer;
    localparam int unsigned WIDTH = 32, LOG2WIDTH = 5, LOG2MVL = 5, REGIDW = 5;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    vlane_shift_sequencer_if #(.WIDTH(WIDTH), .LOG2WIDTH(LOG2WIDTH),
                               .LOG2MVL(LOG2MVL), .REGIDW(REGIDW)) bus ();
    vlane_shift_sequencer #(.WIDTH(WIDTH), .LOG2WIDTH(LOG2WIDTH),
                            .LOG2MVL(LOG2MVL), .REGIDW(REGIDW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-bank register file (combinational read, captured by the DUT next edge).
    logic [31:0] rf_a_mem [32];
    logic [31:0] rf_b_mem [32];
    assign bus.rf_a_data = rf_a_mem[bus.rf_a_addr];
    assign bus.rf_b_data = rf_b_mem[bus.rf_b_addr];

    // One-stage lane shifter; opcode 10 yields garbage so it must never be sent.
    always @(posedge clk) begin
        case (bus.sh_op)
            2'b00:   bus.sh_result <= bus.sh_opB << bus.sh_sa;
            2'b01:   bus.sh_result <= bus.sh_opB >> bus.sh_sa;
            2'b11:   bus.sh_result <= $signed(bus.sh_opB) >>> bus.sh_sa;
            default: bus.sh_result <= ~bus.sh_opB;
        endcase
    end

    int  n_checks = 0, n_pass = 0;
    wb_t exp_q[$];
    int  wb_cycles[$];
    int  rf_cycles[$];
    int  done_cnt = 0, done_cyc = -1;
    int  outstanding = 0, max_out = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void expect_wb(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endfunction

    task automatic run_monitor();
        wb_t         e;
        logic        stall_prev;
        logic [36:0] prev_payload;
        stall_prev = 1'b0;
        prev_payload = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                outstanding = 0;
                stall_prev = 1'b0;
            end else begin
                if (bus.done) begin done_cnt++; done_cyc = cyc; end
                if (bus.rf_re) begin rf_cycles.push_back(cyc); outstanding++; end
                if (outstanding > max_out) max_out = outstanding;
                a_credit: assert (outstanding <= 4)
                    else $error("FAIL credit_overflow: outstanding %0d limit 4", outstanding);
                if (stall_prev) begin
                    chk("wb_hold_valid", 64'(bus.wb_valid), 64'(1));
                    chk("wb_hold_payload", 64'({bus.wb_addr, bus.wb_data}), 64'(prev_payload));
                end
                stall_prev   = bus.wb_valid && !bus.wb_ready;
                prev_payload = {bus.wb_addr, bus.wb_data};
                if (bus.wb_valid && bus.wb_ready) begin
                    wb_cycles.push_back(cyc);
                    outstanding--;
                    chk("wb_expected_pending", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("wb_addr", 64'(bus.wb_addr), 64'(e.addr));
                        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                    end
                end
            end
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [5:0] vl, input logic [4:0] src,
                             input logic [4:0] dst, input logic sav, input logic [4:0] sas,
                             output int c);
        @(posedge clk); #1;
        bus.start = 1'b1;  bus.cmd_op = op;  bus.cmd_vl = vl;  bus.cmd_src = src;
        bus.cmd_dst = dst; bus.cmd_sa_vec = sav; bus.cmd_sa_scalar = sas;
        c = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n0, k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin @(posedge clk); k++; end
        chk("done_seen", 64'(done_cnt - n0), 64'(1));
        dcyc = done_cyc;
    endtask

    initial begin
        int c, d, wb0, rf0, dn0, k;
        bus.start = 1'b0; bus.cmd_op = '0; bus.cmd_vl = '0; bus.cmd_src = '0;
        bus.cmd_dst = '0; bus.cmd_sa_vec = 1'b0; bus.cmd_sa_scalar = '0; bus.wb_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin rf_a_mem[i] = '0; rf_b_mem[i] = '0; end
        fork run_monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
        chk("rst_rf_re", 64'(bus.rf_re), 64'(0));
        chk("rst_sh", 64'({bus.sh_opB, bus.sh_sa, bus.sh_op}), 64'(0));
        chk("rst_addrs", 64'({bus.rf_a_addr, bus.rf_b_addr, bus.wb_addr}), 64'(0));
        chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
        resetn = 1'b1;

        // SLL vl=4 scalar sa=1 into dst 8
        rf_a_mem[0] = 32'd1; rf_a_mem[1] = 32'd2; rf_a_mem[2] = 32'd3; rf_a_mem[3] = 32'h8000_0000;
        expect_wb(5'd8, 32'd2); expect_wb(5'd9, 32'd4); expect_wb(5'd10, 32'd6); expect_wb(5'd11, 32'd0);
        wb0 = wb_cycles.size(); rf0 = rf_cycles.size(); dn0 = done_cnt;
        issue_cmd(2'b00, 6'd4, 5'd0, 5'd8, 1'b0, 5'd1, c);
        chk("t1_busy", 64'(bus.busy), 64'(1));
        wait_done(100, d);
        chk("t1_done_cyc", 64'(d), 64'(c + 8));
        chk("t1_first_rf_re", 64'(rf_cycles[rf0]), 64'(c + 1));
        chk("t1_first_wb", 64'(wb_cycles[wb0]), 64'(c + 4));
        chk("t1_last_wb", 64'(wb_cycles[wb_cycles.size()-1]), 64'(c + 7));
        repeat (4) @(posedge clk);
        chk("t1_done_once", 64'(done_cnt - dn0), 64'(1));
        chk("t1_busy_low", 64'(bus.busy), 64'(0));

        // SRA vl=2, per-element amounts from port B (upper B bits must be ignored)
        rf_a_mem[16] = 32'hF000_0000; rf_b_mem[16] = 32'h0000_0024;
        rf_a_mem[17] = 32'h7FFF_FFFF; rf_b_mem[17] = 32'hFFFF_FFFF;
        expect_wb(5'd4, 32'hFF00_0000); expect_wb(5'd5, 32'h0000_0000);
        issue_cmd(2'b11, 6'd2, 5'd16, 5'd4, 1'b1, 5'd7, c);
        wait_done(100, d);
        chk("t2_done_cyc", 64'(d), 64'(c + 6));

        // SRL vl=32, sa=8, destination wraps from 31
        for (int i = 0; i < 32; i++) begin
            rf_a_mem[i] = {8'(i + 1), 24'h0};
            expect_wb(5'(31 + i), {8'h00, 8'(i + 1), 16'h0000});
        end
        wb0 = wb_cycles.size();
        issue_cmd(2'b01, 6'd32, 5'd0, 5'd31, 1'b0, 5'd8, c);
        wait_done(200, d);
        chk("t3_done_cyc", 64'(d), 64'(c + 36));
        chk("t3_writes", 64'(wb_cycles.size() - wb0), 64'(32));

        // Opcode 10 acts as SLL; wb_ready toggles then stalls for 10 cycles
        for (int i = 0; i < 8; i++) begin
            rf_a_mem[i] = 32'(i + 1);
            expect_wb(5'(20 + i), 32'((i + 1) * 8));
        end
        wb0 = wb_cycles.size(); rf0 = rf_cycles.size(); max_out = 0;
        issue_cmd(2'b10, 6'd8, 5'd0, 5'd20, 1'b0, 5'd3, c);
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; bus.wb_ready = ~bus.wb_ready; end
        @(posedge clk); #1; bus.wb_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1; bus.wb_ready = 1'b1;
        wait_done(200, d);
        chk("t4_writes", 64'(wb_cycles.size() - wb0), 64'(8));
        chk("t4_issues", 64'(rf_cycles.size() - rf0), 64'(8));
        chk("t4_rf_paused", 64'((rf_cycles[rf_cycles.size()-1] - rf_cycles[rf0]) > 7), 64'(1));
        chk("t4_max_outstanding", 64'(max_out), 64'(4));
        chk("t4_queue_empty", 64'(exp_q.size()), 64'(0));

        // vl=0: busy one cycle, done at C+2, no reads or writes
        wb0 = wb_cycles.size(); rf0 = rf_cycles.size();
        issue_cmd(2'b00, 6'd0, 5'd3, 5'd3, 1'b0, 5'd0, c);
        chk("t5_busy", 64'(bus.busy), 64'(1));
        wait_done(20, d);
        chk("t5_done_cyc", 64'(d), 64'(c + 2));
        chk("t5_no_writes", 64'(wb_cycles.size() - wb0), 64'(0));
        chk("t5_no_reads", 64'(rf_cycles.size() - rf0), 64'(0));

        // start while busy is ignored
        expect_wb(5'd0, 32'd1); expect_wb(5'd1, 32'd2);
        wb0 = wb_cycles.size(); dn0 = done_cnt;
        issue_cmd(2'b00, 6'd2, 5'd0, 5'd0, 1'b0, 5'd0, c);
        issue_cmd(2'b01, 6'd5, 5'd3, 5'd12, 1'b0, 5'd1, d);
        wait_done(100, d);
        repeat (10) @(posedge clk);
        chk("t6_writes", 64'(wb_cycles.size() - wb0), 64'(2));
        chk("t6_done_once", 64'(done_cnt - dn0), 64'(1));
        chk("t6_idle", 64'(bus.busy), 64'(0));

        // reset mid-command after three issues, then a clean command
        bus.wb_ready = 1'b0;
        rf0 = rf_cycles.size();
        issue_cmd(2'b00, 6'd8, 5'd0, 5'd16, 1'b0, 5'd2, c);
        k = 0;
        while ((rf_cycles.size() - rf0) < 3 && k < 20) begin @(posedge clk); k++; end
        chk("t7_three_issued", 64'((rf_cycles.size() - rf0) >= 3), 64'(1));
        #1; resetn = 1'b0;
        #1;
        chk("t7_rst_ctrl", 64'({bus.busy, bus.done, bus.rf_re, bus.wb_valid}), 64'(0));
        chk("t7_rst_sh", 64'({bus.sh_opB, bus.sh_sa, bus.sh_op}), 64'(0));
        chk("t7_rst_addr", 64'({bus.rf_a_addr, bus.rf_b_addr, bus.wb_addr}), 64'(0));
        chk("t7_rst_wb_data", 64'(bus.wb_data), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1; bus.wb_ready = 1'b1;
        expect_wb(5'd2, 32'd2); expect_wb(5'd3, 32'd4); expect_wb(5'd4, 32'd6);
        wb0 = wb_cycles.size();
        issue_cmd(2'b00, 6'd3, 5'd0, 5'd2, 1'b0, 5'd1, c);
        wait_done(100, d);
        chk("t7_done_cyc", 64'(d), 64'(c + 7));
        repeat (5) @(posedge clk);
        chk("t7_writes", 64'(wb_cycles.size() - wb0), 64'(3));
        chk("t7_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
